right_barrel_shift_pipe: RTL and testbench

//  Pipelined 32-bit right barrel shifter; companion to the left barrel shifter in the datapath.
//  One log2 stage per pipeline register: stage k shifts right by 2^k when amount bit k is set.

---
 rtl/right_barrel_shift_pipe_pkg.sv | 25 ++
 rtl/right_shift_stage.sv | 79 +++++++
 rtl/right_barrel_shift_pipe.sv | 62 ++++++
 tb/tb_right_barrel_shift_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/right_barrel_shift_pipe_pkg.sv
// rtl/right_barrel_shift_pipe_pkg.sv - shared shift constants, mode encoding and fill helper
`ifndef SHIFT_DEFS_VH
`define SHIFT_DEFS_VH
`define SHIFT_WIDTH   32
`define SHIFT_SHW     5
`define SHIFT_LOGICAL 1'b0
`define SHIFT_ARITH   1'b1
`endif

package right_barrel_shift_pipe_pkg;

  localparam int SHIFT_WIDTH = `SHIFT_WIDTH;
  localparam int SHIFT_SHW   = `SHIFT_SHW;

  typedef enum logic {
    SHIFT_LOGICAL = `SHIFT_LOGICAL,
    SHIFT_ARITH   = `SHIFT_ARITH
  } shift_mode_e;

  // Bit replicated into vacated MSBs: the carried sign in arithmetic mode, zero otherwise.
  function automatic logic fill_bit(input logic arith, input logic sign);
    return arith & sign;
  endfunction

endpackage

// File: rtl/right_shift_stage.sv
// rtl/right_shift_stage.sv - one registered log2 stage of the right barrel shifter
module right_shift_stage
  import right_barrel_shift_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             arith_i,
  input  logic             sign_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output logic             arith_o,
  output logic             sign_o
);

  localparam int BIT = $clog2(DIST);
  localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> DIST);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic             arith_q, arith_d;
  logic             sign_q,  sign_d;
  logic [WIDTH-1:0] shifted;

  // Hold on stall; payload only loads for a valid op so bubbles never disturb the data path.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    arith_d = arith_q;
    sign_d  = sign_q;
    shifted = data_i;
    if (shamt_i[BIT]) begin
      shifted = (data_i >> DIST) | (fill_bit(arith_i, sign_i) ? FILL_MASK : '0);
    end
    if (en) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d  = shifted;
        shamt_d = shamt_i;
        arith_d = arith_i;
        sign_d  = sign_i;
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      arith_q <= arith_d;
      sign_q  <= sign_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign arith_o = arith_q;
  assign sign_o  = sign_q;

endmodule

// File: rtl/right_barrel_shift_pipe.sv
// rtl/right_barrel_shift_pipe.sv - pipelined right barrel shifter, one stage per shift bit
module right_barrel_shift_pipe
  import right_barrel_shift_pipe_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int SHW   = SHIFT_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             advance;
  logic [SHW:0]     valid_c;
  logic [WIDTH-1:0] data_c  [SHW+1];
  logic [SHW-1:0]   shamt_c [SHW+1];
  logic             arith_c [SHW+1];
  logic             sign_c  [SHW+1];

  // Whole pipe moves together; it only freezes when the output holds an untaken result.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign shamt_c[0] = in_shamt;
  assign arith_c[0] = in_arith;
  assign sign_c[0]  = in_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    right_shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .SHW   (SHW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .valid_i (valid_c[k]),
      .data_i  (data_c[k]),
      .shamt_i (shamt_c[k]),
      .arith_i (arith_c[k]),
      .sign_i  (sign_c[k]),
      .valid_o (valid_c[k+1]),
      .data_o  (data_c[k+1]),
      .shamt_o (shamt_c[k+1]),
      .arith_o (arith_c[k+1]),
      .sign_o  (sign_c[k+1])
    );
  end

  assign out_valid = valid_c[SHW];
  assign out_data  = data_c[SHW];

endmodule

// File: tb/tb_right_barrel_shift_pipe.sv
// tb/tb_right_barrel_shift_pipe.sv - randomized scoreboard bench for the right barrel shifter
module tb_right_barrel_shift_pipe;
  import right_barrel_shift_pipe_pkg::*;

  localparam int W = SHIFT_WIDTH;
  localparam int S = SHIFT_SHW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] in_shamt;
  logic         in_arith;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  right_barrel_shift_pipe #(.WIDTH(W), .SHW(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  bit           hold_armed = 0;
  logic [W-1:0] hold_data;
  bit           prev_ok = 0;
  logic [W-1:0] prev_data;
  int           run_len = 0;
  int           max_run = 0;
  int           acc_cnt = 0;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int unsigned s, input logic a);
    if (a) return $unsigned($signed(d) >>> s);
    return d >> s;
  endfunction

  // Scoreboard monitor, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_armed = 0;
      prev_ok = 0;
      run_len = 0;
    end else begin
      if (hold_armed) begin
        check_val("hold_valid", {31'b0, out_valid}, 1);
        check_val("hold_data", out_data, hold_data);
      end
      if (prev_ok && !out_valid) check_val("idle_hold", out_data, prev_data);
      hold_armed = out_valid && !out_ready;
      hold_data = out_data;
      prev_data = out_data;
      prev_ok = 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", {31'b0, out_valid}, 0);
        end else begin
          check_val("data", out_data, exp_q.pop_front());
          got_q.push_back(out_data);
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, in_shamt, in_arith));
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input int unsigned s, input logic a);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = S'(s);
    in_arith = a;
    @(negedge clk);
    while (!in_ready && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check_val("send_timeout", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rand_op();
    in_data = $urandom;
    case ($urandom % 8)
      0:       in_shamt = '0;
      1:       in_shamt = S'(W - 1);
      default: in_shamt = S'($urandom_range(0, W - 1));
    endcase
    in_arith = 1'($urandom % 2);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int abase;
    int lat;
    int cyc;
    int sent;
    bit acc;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_shamt = '0;
    in_arith = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_out_valid", {31'b0, out_valid}, 0);
    check_val("reset_out_data", out_data, 0);
    check_val("reset_in_ready", {31'b0, in_ready}, 1);

    // Single op latency.
    base = got_q.size();
    in_valid = 1'b1;
    in_data = 32'h0040_0000;
    in_shamt = 5'd1;
    in_arith = SHIFT_LOGICAL;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", lat, 5);
    check_val("t1_data", out_data, 32'h0020_0000);
    drain();

    // Boundary amounts on the sign bit.
    base = got_q.size();
    send(32'h8000_0000, 31, SHIFT_LOGICAL);
    send(32'h8000_0000, 31, SHIFT_ARITH);
    send(32'h8000_0000, 0, SHIFT_ARITH);
    send(32'h8000_0000, 0, SHIFT_LOGICAL);
    drain();
    check_val("t2_count", got_q.size() - base, 4);
    if (got_q.size() - base == 4) begin
      check_val("t2_log31", got_q[base], 32'h0000_0001);
      check_val("t2_ari31", got_q[base+1], 32'hFFFF_FFFF);
      check_val("t2_ari0", got_q[base+2], 32'h8000_0000);
      check_val("t2_log0", got_q[base+3], 32'h8000_0000);
    end

    // Back-to-back stream.
    base = got_q.size();
    max_run = 0;
    for (int i = 0; i < 8; i++) send(32'(i) << 28, i, 1'(i % 2));
    drain();
    check_val("t3_count", got_q.size() - base, 8);
    check_val("t3_consecutive", max_run, 8);

    // Back-pressure for 10 cycles while streaming.
    base = got_q.size();
    abase = acc_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_op();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) rand_op();
    end
    check_val("stall_in_ready", {31'b0, in_ready}, 0);
    check_val("stall_out_valid", {31'b0, out_valid}, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check_val("stall_count", got_q.size() - base, acc_cnt - abase);

    // Reset with ops in flight.
    base = got_q.size();
    send(32'h1234_5678, 3, SHIFT_LOGICAL);
    send(32'h8765_4321, 7, SHIFT_ARITH);
    send(32'hFFFF_0000, 16, SHIFT_ARITH);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_out_valid", {31'b0, out_valid}, 0);
    check_val("rst_out_data", out_data, 0);
    repeat (10) @(posedge clk);
    #1;
    check_val("rst_discard", got_q.size() - base, 0);
    send(32'hF000_000F, 4, SHIFT_ARITH);
    drain();
    check_val("post_rst_count", got_q.size() - base, 1);
    if (got_q.size() - base == 1) check_val("post_rst_data", got_q[base], 32'hFF00_0000);

    // Random traffic.
    base = got_q.size();
    abase = acc_cnt;
    cyc = 0;
    sent = 0;
    in_valid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!in_valid && ($urandom % 4 != 0)) begin
        in_valid = 1'b1;
        rand_op();
      end
      out_ready = ($urandom % 4 != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    check_val("rand_sent", sent, 10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check_val("rand_count", got_q.size() - base, acc_cnt - abase);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
